// File: rtl/camera_scroller_pkg.sv
// Camera scroller shared types and defaults.
// Holds the scroll state enumeration and default level geometry.
package camera_scroller_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SCROLL_UP   = 2'd1,
    SCROLL_DOWN = 2'd2
  } state_e;

  localparam int SCREEN_H_DEF    = 480;
  localparam int SCROLL_STEP_DEF = 8;
  localparam int MAX_LEVEL_DEF   = 63;

endpackage

// File: rtl/camera_scroller_if.sv
// Camera scroller bus: frame_tick/enable/player_y in,
// camera_y/offset/base, scroll_busy, level_pulse out.
interface camera_scroller_if #(
  parameter int PHY_WIDTH    = 16,
  parameter int CAMERA_WIDTH = 6
);

  logic                    frame_tick;
  logic                    enable;
  logic [PHY_WIDTH-1:0]    player_y;
  logic [CAMERA_WIDTH-1:0] camera_y;
  logic [PHY_WIDTH-1:0]    camera_offset;
  logic [PHY_WIDTH-1:0]    camera_base;
  logic                    scroll_busy;
  logic                    level_pulse;

  modport master (
    output frame_tick,
    output enable,
    output player_y,
    input  camera_y,
    input  camera_offset,
    input  camera_base,
    input  scroll_busy,
    input  level_pulse
  );

  modport slave (
    input  frame_tick,
    input  enable,
    input  player_y,
    output camera_y,
    output camera_offset,
    output camera_base,
    output scroll_busy,
    output level_pulse
  );

endinterface

// File: rtl/camera_scroller.sv
// Level-by-level vertical camera scroller.
// Ports: clk, rst_n (sync, active-low), bus (slave modport).
module camera_scroller
  import camera_scroller_pkg::*;
#(
  parameter int PHY_WIDTH    = 16,
  parameter int CAMERA_WIDTH = 6,
  parameter int SCREEN_H     = SCREEN_H_DEF,
  parameter int SCROLL_STEP  = SCROLL_STEP_DEF,
  parameter int MAX_LEVEL    = MAX_LEVEL_DEF
) (
  input logic               clk,
  input logic               rst_n,
  camera_scroller_if.slave  bus
);

  localparam logic [PHY_WIDTH-1:0] H =
    PHY_WIDTH'(SCREEN_H);
  localparam logic [PHY_WIDTH-1:0] STEP =
    PHY_WIDTH'(SCROLL_STEP);
  localparam logic [PHY_WIDTH-1:0] LAST =
    PHY_WIDTH'(SCREEN_H - SCROLL_STEP);
  localparam logic [CAMERA_WIDTH-1:0] MAXL =
    CAMERA_WIDTH'(MAX_LEVEL);
  localparam logic [CAMERA_WIDTH-1:0] ONE =
    CAMERA_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [CAMERA_WIDTH-1:0] cam_y_q, cam_y_d;
  logic [PHY_WIDTH-1:0]    base_q, base_d;
  logic [PHY_WIDTH-1:0]    off_q, off_d;
  logic                    pulse_q, pulse_d;

  // One extra bit so the level top never wraps.
  logic [PHY_WIDTH:0] top;
  logic               want_up;
  logic               want_dn;

  assign top = {1'b0, base_q} + {1'b0, H};

  assign want_up = bus.enable
                && ({1'b0, bus.player_y} >= top)
                && (cam_y_q < MAXL);

  assign want_dn = bus.enable
                && (bus.player_y < base_q)
                && (cam_y_q != '0);

  always_comb begin
    state_d = state_q;
    cam_y_d = cam_y_q;
    base_d  = base_q;
    off_d   = off_q;
    pulse_d = 1'b0;
    if (bus.frame_tick) begin
      unique case (state_q)
        IDLE: begin
          if (want_up) begin
            state_d = SCROLL_UP;
            off_d   = off_q + STEP;
          end else if (want_dn) begin
            // Drop a level first so base+offset
            // stays continuous.
            state_d = SCROLL_DOWN;
            cam_y_d = cam_y_q - ONE;
            base_d  = base_q - H;
            off_d   = LAST;
            pulse_d = 1'b1;
          end
        end
        SCROLL_UP: begin
          if (off_q == LAST) begin
            state_d = IDLE;
            cam_y_d = cam_y_q + ONE;
            base_d  = base_q + H;
            off_d   = '0;
            pulse_d = 1'b1;
          end else begin
            off_d = off_q + STEP;
          end
        end
        SCROLL_DOWN: begin
          off_d = off_q - STEP;
          if (off_q == STEP) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cam_y_q <= '0;
      base_q  <= '0;
      off_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cam_y_q <= cam_y_d;
      base_q  <= base_d;
      off_q   <= off_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.camera_y      = cam_y_q;
  assign bus.camera_base   = base_q;
  assign bus.camera_offset = off_q;
  assign bus.scroll_busy   = (state_q != IDLE);
  assign bus.level_pulse   = pulse_q;

endmodule

// File: tb/tb_camera_scroller.sv
// Camera scroller bench: window-position model
// plus directed scenarios with literal expectations.
module tb_camera_scroller;

  localparam int H    = 480;
  localparam int STEP = 8;
  localparam int MAXL = 63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  camera_scroller_if #(
    .PHY_WIDTH(16),
    .CAMERA_WIDTH(6)
  ) bus ();

  camera_scroller dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Inputs as seen by the DUT at the last edge.
  logic        s_rst_n = 1'b0;
  logic        s_tick  = 1'b0;
  logic        s_en    = 1'b0;
  logic [15:0] s_py    = '0;

  always @(posedge clk) begin
    s_rst_n <= rst_n;
    s_tick  <= bus.frame_tick;
    s_en    <= bus.enable;
    s_py    <= bus.player_y;
  end

  // Model: the window bottom in pixels plus a
  // scroll direction; level/offset derive by div/mod.
  int m_win = 0;
  int m_dir = 0;
  int m_lvl;
  bit m_pulse = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!s_rst_n) begin
        m_win   = 0;
        m_dir   = 0;
        m_pulse = 0;
      end else begin
        m_pulse = 0;
        if (s_tick) begin
          m_lvl = m_win / H;
          if (m_dir == 0 && s_en) begin
            if (int'(s_py) / H > m_lvl && m_lvl < MAXL)
              m_dir = 1;
            else if (int'(s_py) < m_lvl * H && m_lvl > 0)
              m_dir = -1;
          end
          m_win = m_win + m_dir * STEP;
          if (m_win / H != m_lvl) m_pulse = 1;
          if (m_win % H == 0) m_dir = 0;
        end
      end
      chk("camera_y", int'(bus.camera_y), m_win / H);
      chk("camera_offset", int'(bus.camera_offset),
          m_win % H);
      chk("camera_base", int'(bus.camera_base),
          (m_win / H) * H);
      chk("scroll_busy", int'(bus.scroll_busy),
          int'(m_dir != 0));
      chk("level_pulse", int'(bus.level_pulse),
          int'(m_pulse));
      if (bus.level_pulse) pulse_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int p0;

  initial begin
    bus.frame_tick = 1'b0;
    bus.enable     = 1'b1;
    bus.player_y   = 16'd100;
    step();
    step();
    step();
    rst_n = 1'b1;
    chk("rst_y", int'(bus.camera_y), 0);
    chk("rst_busy", int'(bus.scroll_busy), 0);

    tick(10);
    chk("idle_y", int'(bus.camera_y), 0);
    chk("idle_off", int'(bus.camera_offset), 0);
    chk("idle_busy", int'(bus.scroll_busy), 0);

    bus.player_y = 16'd500;
    p0 = pulse_cnt;
    tick(1);
    chk("up_first_off", int'(bus.camera_offset), 8);
    tick(58);
    chk("up59_off", int'(bus.camera_offset), 472);
    chk("up59_y", int'(bus.camera_y), 0);
    chk("up59_busy", int'(bus.scroll_busy), 1);
    tick(1);
    chk("up60_y", int'(bus.camera_y), 1);
    chk("up60_base", int'(bus.camera_base), 480);
    chk("up60_off", int'(bus.camera_offset), 0);
    chk("up60_busy", int'(bus.scroll_busy), 0);
    @(negedge clk);
    #1;
    chk("up_pulses", pulse_cnt - p0, 1);

    bus.player_y = 16'd100;
    bus.frame_tick = 1'b1;
    step();
    chk("dn1_pulse", int'(bus.level_pulse), 1);
    bus.frame_tick = 1'b0;
    step();
    chk("dn1_y", int'(bus.camera_y), 0);
    chk("dn1_off", int'(bus.camera_offset), 472);
    chk("dn1_pulse_gone", int'(bus.level_pulse), 0);
    tick(59);
    chk("dn_end_off", int'(bus.camera_offset), 0);
    chk("dn_end_busy", int'(bus.scroll_busy), 0);
    chk("dn_end_y", int'(bus.camera_y), 0);

    bus.player_y = 16'd1500;
    tick(180);
    chk("multi_y", int'(bus.camera_y), 3);
    chk("multi_base", int'(bus.camera_base), 1440);
    chk("multi_busy", int'(bus.scroll_busy), 0);
    tick(5);
    chk("multi_stay_y", int'(bus.camera_y), 3);

    do_reset();
    bus.enable   = 1'b0;
    bus.player_y = 16'd500;
    tick(10);
    chk("en0_busy", int'(bus.scroll_busy), 0);
    chk("en0_off", int'(bus.camera_offset), 0);
    bus.enable = 1'b1;
    tick(25);
    chk("en_mid_off", int'(bus.camera_offset), 200);
    bus.enable = 1'b0;
    tick(35);
    chk("en_done_y", int'(bus.camera_y), 1);
    chk("en_done_off", int'(bus.camera_offset), 0);
    chk("en_done_busy", int'(bus.scroll_busy), 0);

    do_reset();
    bus.enable   = 1'b1;
    bus.player_y = 16'd65000;
    tick(63 * 60);
    chk("top_y", int'(bus.camera_y), 63);
    chk("top_base", int'(bus.camera_base), 30240);
    tick(10);
    chk("top_stay_y", int'(bus.camera_y), 63);
    chk("top_busy", int'(bus.scroll_busy), 0);
    chk("top_off", int'(bus.camera_offset), 0);

    do_reset();
    bus.player_y = 16'd500;
    tick(30);
    chk("mid_off", int'(bus.camera_offset), 240);
    rst_n = 1'b0;
    bus.frame_tick = 1'b1;
    step();
    chk("mrst_y", int'(bus.camera_y), 0);
    chk("mrst_off", int'(bus.camera_offset), 0);
    chk("mrst_base", int'(bus.camera_base), 0);
    chk("mrst_busy", int'(bus.scroll_busy), 0);
    chk("mrst_pulse", int'(bus.level_pulse), 0);
    step();
    chk("mrst2_off", int'(bus.camera_offset), 0);
    bus.frame_tick = 1'b0;
    rst_n = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
